// File: rtl/fft_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fft_pkg                                                                  |
// | Shared constants, sample type, read-FSM states and index bit-reversal.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package fft_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int N_POINTS   = 8;
  localparam int LOG2_N     = $clog2(N_POINTS);

  typedef logic signed [DATA_WIDTH-1:0] sample_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

  // Reverses the low nbits of idx; bits above nbits come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int nbits);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 32; b++) begin
      if (b < nbits) r[nbits-1-b] = idx[b];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_bitrev_reorder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fft_bitrev_reorder                                                       |
// | Ping-pong frame buffer re-emitting natural-order frames bit-reversed.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fft_bitrev_reorder #(
  parameter int DATA_WIDTH = 16,
  parameter int N_POINTS   = 8
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic                         en_in,
  input  logic signed [DATA_WIDTH-1:0] src_data_in,
  input  logic                         src_valid_in,
  input  logic                         src_sop_in,
  output logic signed [DATA_WIDTH-1:0] dst_data_out,
  output logic                         dst_valid_out,
  output logic                         dst_last_out
);
  import fft_pkg::bitrev;
  import fft_pkg::rd_state_e;
  import fft_pkg::RD_IDLE;
  import fft_pkg::RD_READ;

  localparam int                LOG2_N   = $clog2(N_POINTS);
  localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(N_POINTS - 1);
  localparam logic [LOG2_N-1:0] IDX_ONE  = LOG2_N'(1);

  logic signed [DATA_WIDTH-1:0] bank_q [2][N_POINTS];

  logic [LOG2_N-1:0]            wr_idx_q, wr_idx_d, wr_ptr;
  logic                         wr_bank_q, wr_bank_d;
  logic [LOG2_N-1:0]            rd_idx_q, rd_idx_d, rd_addr;
  logic                         rd_bank_q, rd_bank_d;
  rd_state_e                    state_q, state_d;
  logic signed [DATA_WIDTH-1:0] data_q, data_d;
  logic                         valid_q, valid_d;
  logic                         last_q, last_d;
  logic                         accept, complete, rd_last;

  always_comb begin
    accept    = en_in & src_valid_in;
    // A start-of-frame restarts the write bank at slot 0, dropping any partial frame.
    wr_ptr    = src_sop_in ? '0 : wr_idx_q;
    complete  = accept && (wr_ptr == LAST_IDX);
    rd_last   = (state_q == RD_READ) && (rd_idx_q == LAST_IDX);
    rd_addr   = LOG2_N'(bitrev(32'(rd_idx_q), LOG2_N));

    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    rd_idx_d  = rd_idx_q;
    rd_bank_d = rd_bank_q;
    state_d   = state_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;

    if (accept) begin
      wr_idx_d = wr_ptr + IDX_ONE;
      if (complete) wr_bank_d = ~wr_bank_q;
    end

    if (en_in) begin
      case (state_q)
        RD_IDLE: begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (complete) state_d = RD_READ;
        end
        RD_READ: begin
          data_d   = bank_q[rd_bank_q][rd_addr];
          valid_d  = 1'b1;
          last_d   = rd_last;
          rd_idx_d = rd_idx_q + IDX_ONE;
          if (rd_last && !complete) state_d = RD_IDLE;
        end
        default: state_d = RD_IDLE;
      endcase
      // A completion always lands on an idle reader or on its final output.
      if (complete) begin
        rd_idx_d  = '0;
        rd_bank_d = wr_bank_q;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N_POINTS; i++) begin
          bank_q[b][i] <= '0;
        end
      end
      wr_idx_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_idx_q  <= '0;
      rd_bank_q <= 1'b0;
      state_q   <= RD_IDLE;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      if (accept) bank_q[wr_bank_q][wr_ptr] <= src_data_in;
      wr_idx_q  <= wr_idx_d;
      wr_bank_q <= wr_bank_d;
      rd_idx_q  <= rd_idx_d;
      rd_bank_q <= rd_bank_d;
      state_q   <= state_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
    end
  end

  assign dst_data_out  = data_q;
  assign dst_valid_out = valid_q;
  assign dst_last_out  = last_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_bitrev_reorder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fft_bitrev_reorder                                                    |
// | Scoreboard bench for the 8-point bit-reversal reorder stage.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fft_bitrev_reorder;
  localparam int DW = 16;
  localparam int NP = 8;

  logic                 clk = 1'b0;
  logic                 arst_n;
  logic                 en_in;
  logic signed [DW-1:0] src_data_in;
  logic                 src_valid_in;
  logic                 src_sop_in;
  logic signed [DW-1:0] dst_data_out;
  logic                 dst_valid_out;
  logic                 dst_last_out;

  typedef struct {
    bit                   v;
    bit                   sop;
    bit                   en;
    logic signed [DW-1:0] d;
  } stim_t;

  typedef struct {
    logic signed [DW-1:0] d;
    bit                   last;
  } exp_t;

  stim_t                stim_q[$];
  exp_t                 exp_q[$];
  logic signed [DW-1:0] m_frame [NP];
  int                   m_idx = 0;
  int                   checks = 0;
  int                   failures = 0;

  fft_bitrev_reorder #(.DATA_WIDTH(DW), .N_POINTS(NP)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .en_in        (en_in),
    .src_data_in  (src_data_in),
    .src_valid_in (src_valid_in),
    .src_sop_in   (src_sop_in),
    .dst_data_out (dst_data_out),
    .dst_valid_out(dst_valid_out),
    .dst_last_out (dst_last_out)
  );

  always #5 clk = ~clk;

  function automatic int brev3(input int k);
    logic [2:0] kk;
    kk = 3'(k);
    return int'({kk[0], kk[1], kk[2]});
  endfunction

  task automatic push_frame(input int base, input int n, input bit sop_first, input bit gapped);
    for (int k = 0; k < n; k++) begin
      stim_q.push_back('{v: 1'b1, sop: (sop_first && k == 0), en: 1'b1, d: DW'(base + k)});
      if (gapped) stim_q.push_back('{v: 1'b0, sop: 1'b0, en: 1'b1, d: '0});
    end
  endtask

  task automatic push_idle(input int n, input bit en);
    for (int k = 0; k < n; k++) stim_q.push_back('{v: 1'b0, sop: 1'b0, en: en, d: '0});
  endtask

  // Applies one cycle of stimulus, updates the frame model, returns #1 after the edge.
  task automatic drive_cycle(input stim_t s);
    int   ptr;
    exp_t e;
    en_in        = s.en;
    src_valid_in = s.v;
    src_sop_in   = s.sop;
    src_data_in  = s.d;
    if (s.en && s.v) begin
      ptr = s.sop ? 0 : m_idx;
      m_frame[ptr] = s.d;
      if (ptr == NP - 1) begin
        for (int k = 0; k < NP; k++) begin
          e.d    = m_frame[brev3(k)];
          e.last = (k == NP - 1);
          exp_q.push_back(e);
        end
        m_idx = 0;
      end else begin
        m_idx = ptr + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arst_n = 1'b0; en_in = 1'b1; src_valid_in = 1'b0; src_sop_in = 1'b0; src_data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (dst_valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", dst_valid_out); end
    checks++; if (dst_last_out !== 1'b0) begin failures++; $display("FAIL reset_last: got %b want 0", dst_last_out); end
    checks++; if (dst_data_out !== '0) begin failures++; $display("FAIL reset_data: got %0d want 0", dst_data_out); end
    @(negedge clk) arst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (dst_valid_out !== 1'b0) begin failures++; $display("FAIL reset_release_valid: got %b want 0", dst_valid_out); end
  endtask

  task automatic test_single_frame();
    int first = -1, lastv = -1, nval = 0;
    exp_t e;
    stim_q.delete();
    push_frame(1, NP, 1'b0, 1'b0);
    push_idle(10, 1'b1);
    for (int i = 0; i < stim_q.size(); i++) begin
      drive_cycle(stim_q[i]);
      if (dst_valid_out === 1'b1) begin
        if (first < 0) first = i;
        lastv = i; nval++; checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL single_extra: got %0d want none", dst_data_out); end
        else begin
          e = exp_q.pop_front();
          if (dst_data_out !== e.d || dst_last_out !== e.last) begin
            failures++; $display("FAIL single_data: got %0d/last=%b want %0d/last=%b", dst_data_out, dst_last_out, e.d, e.last);
          end
        end
      end
    end
    checks++; if (nval != NP) begin failures++; $display("FAIL single_count: got %0d want %0d", nval, NP); end
    checks++; if (first != NP) begin failures++; $display("FAIL single_latency: got %0d want %0d", first, NP); end
    checks++; if (lastv - first + 1 != NP) begin failures++; $display("FAIL single_span: got %0d want %0d", lastv - first + 1, NP); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL single_left: got %0d want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_back_to_back();
    int first = -1, lastv = -1, nval = 0;
    exp_t e;
    stim_q.delete();
    push_frame(1, NP, 1'b0, 1'b0);
    push_frame(11, NP, 1'b0, 1'b0);
    push_idle(10, 1'b1);
    for (int i = 0; i < stim_q.size(); i++) begin
      drive_cycle(stim_q[i]);
      if (dst_valid_out === 1'b1) begin
        if (first < 0) first = i;
        lastv = i; nval++; checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL b2b_extra: got %0d want none", dst_data_out); end
        else begin
          e = exp_q.pop_front();
          if (dst_data_out !== e.d || dst_last_out !== e.last) begin
            failures++; $display("FAIL b2b_data: got %0d/last=%b want %0d/last=%b", dst_data_out, dst_last_out, e.d, e.last);
          end
        end
      end
    end
    checks++; if (nval != 2 * NP) begin failures++; $display("FAIL b2b_count: got %0d want %0d", nval, 2 * NP); end
    checks++; if (lastv - first + 1 != 2 * NP) begin failures++; $display("FAIL b2b_contiguous: got span %0d want %0d", lastv - first + 1, 2 * NP); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_left: got %0d want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_enable_stall();
    int first = -1, lastv = -1, nval = 0;
    exp_t e;
    logic signed [DW-1:0] held = '0;
    stim_q.delete();
    push_frame(1, NP, 1'b0, 1'b0);
    push_idle(3, 1'b1);
    push_idle(3, 1'b0);
    push_idle(10, 1'b1);
    for (int i = 0; i < stim_q.size(); i++) begin
      drive_cycle(stim_q[i]);
      if (!stim_q[i].en) begin
        checks++;
        if (dst_valid_out !== 1'b1 || dst_data_out !== held || dst_last_out !== 1'b0) begin
          failures++; $display("FAIL stall_hold: got %0d/valid=%b/last=%b want %0d/valid=1/last=0", dst_data_out, dst_valid_out, dst_last_out, held);
        end
      end else if (dst_valid_out === 1'b1) begin
        if (first < 0) first = i;
        lastv = i; nval++; checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL stall_extra: got %0d want none", dst_data_out); end
        else begin
          e = exp_q.pop_front();
          held = e.d;
          if (dst_data_out !== e.d || dst_last_out !== e.last) begin
            failures++; $display("FAIL stall_data: got %0d/last=%b want %0d/last=%b", dst_data_out, dst_last_out, e.d, e.last);
          end
        end
      end
    end
    checks++; if (nval != NP) begin failures++; $display("FAIL stall_count: got %0d want %0d", nval, NP); end
    checks++; if (lastv - first + 1 != NP + 3) begin failures++; $display("FAIL stall_span: got %0d want %0d", lastv - first + 1, NP + 3); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL stall_left: got %0d want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_sop_restart();
    int first = -1, nval = 0;
    exp_t e;
    stim_q.delete();
    push_frame(1, 5, 1'b0, 1'b0);
    push_frame(21, NP, 1'b1, 1'b0);
    push_idle(10, 1'b1);
    for (int i = 0; i < stim_q.size(); i++) begin
      drive_cycle(stim_q[i]);
      if (dst_valid_out === 1'b1) begin
        if (first < 0) first = i;
        nval++; checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL sop_extra: got %0d want none", dst_data_out); end
        else begin
          e = exp_q.pop_front();
          if (dst_data_out !== e.d || dst_last_out !== e.last) begin
            failures++; $display("FAIL sop_data: got %0d/last=%b want %0d/last=%b", dst_data_out, dst_last_out, e.d, e.last);
          end
        end
      end
    end
    checks++; if (nval != NP) begin failures++; $display("FAIL sop_count: got %0d want %0d", nval, NP); end
    checks++; if (first != 5 + NP) begin failures++; $display("FAIL sop_latency: got %0d want %0d", first, 5 + NP); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL sop_left: got %0d want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_midread();
    int first = -1, nval = 0;
    exp_t e;
    stim_q.delete();
    push_frame(41, NP, 1'b0, 1'b0);
    push_idle(12, 1'b1);
    for (int i = 0; i < stim_q.size(); i++) begin
      drive_cycle(stim_q[i]);
      if (dst_valid_out === 1'b1) begin
        nval++; checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL rst_pre_extra: got %0d want none", dst_data_out); end
        else begin
          e = exp_q.pop_front();
          if (dst_data_out !== e.d) begin failures++; $display("FAIL rst_pre_data: got %0d want %0d", dst_data_out, e.d); end
        end
      end
      if (nval == 4) break;
    end
    checks++; if (nval != 4) begin failures++; $display("FAIL rst_pre_count: got %0d want 4", nval); end
    arst_n = 1'b0;
    #1;
    checks++;
    if (dst_valid_out !== 1'b0 || dst_last_out !== 1'b0 || dst_data_out !== '0) begin
      failures++; $display("FAIL rst_async: got %0d/valid=%b/last=%b want 0/0/0", dst_data_out, dst_valid_out, dst_last_out);
    end
    #2 arst_n = 1'b1;
    exp_q.delete();
    m_idx = 0;
    stim_q.delete();
    push_idle(3, 1'b1);
    push_frame(31, NP, 1'b0, 1'b0);
    push_idle(10, 1'b1);
    nval = 0;
    for (int i = 0; i < stim_q.size(); i++) begin
      drive_cycle(stim_q[i]);
      if (i < 3) begin
        checks++;
        if (dst_valid_out !== 1'b0) begin failures++; $display("FAIL rst_post_quiet: got valid=%b want 0", dst_valid_out); end
      end else if (dst_valid_out === 1'b1) begin
        if (first < 0) first = i;
        nval++; checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL rst_post_extra: got %0d want none", dst_data_out); end
        else begin
          e = exp_q.pop_front();
          if (dst_data_out !== e.d || dst_last_out !== e.last) begin
            failures++; $display("FAIL rst_post_data: got %0d/last=%b want %0d/last=%b", dst_data_out, dst_last_out, e.d, e.last);
          end
        end
      end
    end
    checks++; if (nval != NP) begin failures++; $display("FAIL rst_post_count: got %0d want %0d", nval, NP); end
    checks++; if (first != 3 + NP) begin failures++; $display("FAIL rst_post_latency: got %0d want %0d", first, 3 + NP); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rst_post_left: got %0d want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_gapped_valid();
    int first = -1, lastv = -1, nval = 0;
    exp_t e;
    stim_q.delete();
    push_frame(1, NP, 1'b0, 1'b1);
    push_idle(10, 1'b1);
    for (int i = 0; i < stim_q.size(); i++) begin
      drive_cycle(stim_q[i]);
      if (dst_valid_out === 1'b1) begin
        if (first < 0) first = i;
        lastv = i; nval++; checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL gap_extra: got %0d want none", dst_data_out); end
        else begin
          e = exp_q.pop_front();
          if (dst_data_out !== e.d || dst_last_out !== e.last) begin
            failures++; $display("FAIL gap_data: got %0d/last=%b want %0d/last=%b", dst_data_out, dst_last_out, e.d, e.last);
          end
        end
      end
    end
    checks++; if (nval != NP) begin failures++; $display("FAIL gap_count: got %0d want %0d", nval, NP); end
    checks++; if (first != 2 * NP - 1) begin failures++; $display("FAIL gap_latency: got %0d want %0d", first, 2 * NP - 1); end
    checks++; if (lastv - first + 1 != NP) begin failures++; $display("FAIL gap_span: got %0d want %0d", lastv - first + 1, NP); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL gap_left: got %0d want 0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_enable_stall();
    test_sop_restart();
    test_reset_midread();
    test_gapped_valid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
